booth_control_unit: RTL and testbench

One-hot control unit for the radix-2 Booth sequential multiplier. It holds one state flip-flop per state and an iteration counter, and decodes Moore control strobes for the A/Q/M datapath registers. It sits directly upstream of the datapath register load/shift enables and consumes the datapath's Q[0]/Q[-1] bit pair.

---
 rtl/booth_control_unit.sv | 124 ++++++++++++
 tb/tb_booth_control_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/booth_control_unit.sv
// rtl/booth_control_unit.sv - one-hot control FSM for a radix-2 Booth sequential multiplier
//
// Sequences the A/Q/M datapath of a radix-2 Booth multiplier. There is one
// flip-flop per state plus an iteration counter. All control strobes are
// Moore outputs decoded from the state vector.
//
// Optional feature macro: BOOTH_ONEHOT_CHECK_EN
//   defined   : a non-one-hot state vector raises illegal_state, and the
//               next edge forces IDLE and clears cnt
//   undefined : illegal_state is tied low; corrupted states follow the
//               plain per-bit equations
//
// Parameters
//   WIDTH          operand width and number of Booth iterations (>= 2)
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous active-high reset
//   start          begin a multiplication (sampled only in IDLE)
//   q0, q_minus1   datapath Q[0] / Q[-1] (sampled only in CHECK)
//   load           A<=0, Q<=multiplier, M<=multiplicand, Q[-1]<=0
//   add            A <= A + M
//   sub            A <= A - M
//   shift          arithmetic right shift of {A,Q,Q[-1]}
//   busy           high in every state except IDLE
//   done           one-cycle result-valid strobe
//   state          one-hot {DONE,SHIFT,SUB,ADD,CHECK,LOAD,IDLE}, IDLE = bit 0
//   illegal_state  state vector not one-hot (feature macro only)

module booth_control_unit #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       q0,
    input  logic       q_minus1,
    output logic       load,
    output logic       add,
    output logic       sub,
    output logic       shift,
    output logic       busy,
    output logic       done,
    output logic [6:0] state,
    output logic       illegal_state
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    // Bit positions of each state inside the one-hot vector.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CHECK = 3'd2,
        S_ADD   = 3'd3,
        S_SUB   = 3'd4,
        S_SHIFT = 3'd5,
        S_DONE  = 3'd6
    } state_bit_e;

    localparam logic [6:0] STATE_RESET = 7'b0000001;

    logic [6:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          cnt_last;
    logic          bad_state;

    assign cnt_last = (cnt_q == CNT_LAST);

`ifdef BOOTH_ONEHOT_CHECK_EN
    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    assign bad_state = (state_q == 7'd0) || ((state_q & (state_q - 7'd1)) != 7'd0);
`else
    assign bad_state = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= STATE_RESET;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Per-bit next-state equations. Each bit is built independently, so a
    // corrupted vector keeps evolving bit by bit unless recovery is enabled.
    always_comb begin
        state_d = '0;
        cnt_d   = cnt_q;

        state_d[S_IDLE]  = (state_q[S_IDLE] & ~start) | state_q[S_DONE];
        state_d[S_LOAD]  = state_q[S_IDLE] & start;
        state_d[S_CHECK] = state_q[S_LOAD] | (state_q[S_SHIFT] & ~cnt_last);
        state_d[S_ADD]   = state_q[S_CHECK] & ~q0 &  q_minus1;
        state_d[S_SUB]   = state_q[S_CHECK] &  q0 & ~q_minus1;
        state_d[S_SHIFT] = (state_q[S_CHECK] & (q0 == q_minus1))
                         | state_q[S_ADD] | state_q[S_SUB];
        state_d[S_DONE]  = state_q[S_SHIFT] & cnt_last;

        if (state_q[S_LOAD]) begin
            cnt_d = '0;
        end else if (state_q[S_SHIFT]) begin
            cnt_d = cnt_last ? '0 : cnt_q + CW'(1);
        end

        if (bad_state) begin
            state_d = STATE_RESET;
            cnt_d   = '0;
        end
    end

    assign load          = state_q[S_LOAD];
    assign add           = state_q[S_ADD];
    assign sub           = state_q[S_SUB];
    assign shift         = state_q[S_SHIFT];
    assign done          = state_q[S_DONE];
    assign busy          = ~state_q[S_IDLE];
    assign state         = state_q;
    assign illegal_state = bad_state;

endmodule

// File: tb/tb_booth_control_unit.sv
// tb/tb_booth_control_unit.sv - directed self-checking bench for booth_control_unit
module tb_booth_control_unit;

    logic       clk;
    logic       reset;
    logic       start;
    logic       q0;
    logic       q_minus1;
    logic       load;
    logic       add;
    logic       sub;
    logic       shift;
    logic       busy;
    logic       done;
    logic [6:0] state;
    logic       illegal_state;

    int total;
    int bad;
    int illegal_seen;

    booth_control_unit #(.WIDTH(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .q0            (q0),
        .q_minus1      (q_minus1),
        .load          (load),
        .add           (add),
        .sub           (sub),
        .shift         (shift),
        .busy          (busy),
        .done          (done),
        .state         (state),
        .illegal_state (illegal_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs change and outputs are sampled #1 after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (illegal_state) illegal_seen++;
    endtask

    // One operation with {q0,q_minus1} held. Returns strobe counts, the cycle
    // (relative to the start-sampling edge 0) in which done was seen, the number
    // of busy cycles, and a count of protocol violations (overlapping strobes,
    // add/sub not followed by shift).
    task automatic run_op(input logic [1:0] qbits, input bit restart_c5,
                          output int nsh, output int nadd, output int nsub,
                          output int ndone, output int dcyc, output int nbusy,
                          output int viol);
        int  strobes;
        bit  prev_as;
        nsh = 0; nadd = 0; nsub = 0; ndone = 0; dcyc = -1; nbusy = 0; viol = 0;
        prev_as = 1'b0;
        {q0, q_minus1} = qbits;
        start = 1'b1;
        step();                                  // edge 0
        start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            strobes = int'(load) + int'(add) + int'(sub) + int'(shift);
            if (strobes > 1) viol++;
            if (prev_as && !shift) viol++;
            prev_as = add | sub;
            if (shift) nsh++;
            if (add)   nadd++;
            if (sub)   nsub++;
            if (busy)  nbusy++;
            if (done) begin
                ndone++;
                dcyc = c;
            end
            start = (restart_c5 && c == 5) ? 1'b1 : 1'b0;
            step();
        end
        start = 1'b0;
    endtask

    int nsh, nadd, nsub, ndone, dcyc, nbusy, viol;
    int load_cycles[$];
    int done_cycles[$];
    int subs;

    initial begin
        total = 0;
        bad = 0;
        illegal_seen = 0;
        reset = 1'b0;
        start = 1'b0;
        q0 = 1'b0;
        q_minus1 = 1'b0;

        // Reset asserted before any clock edge: takes effect asynchronously.
        #2 reset = 1'b1;
        #1;
        check("reset_state_async", int'(state), 1);
        check("reset_outputs_async", int'({load, add, sub, shift, busy, done}), 0);
        check("reset_illegal", int'(illegal_state), 0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        repeat (3) step();
        check("idle_after_reset_state", int'(state), 1);
        check("idle_after_reset_busy", int'(busy), 0);

        // {q0,q_minus1} = 00: shifts only.
        run_op(2'b00, 1'b0, nsh, nadd, nsub, ndone, dcyc, nbusy, viol);
        check("p00_shifts", nsh, 8);
        check("p00_adds", nadd, 0);
        check("p00_subs", nsub, 0);
        check("p00_done_count", ndone, 1);
        check("p00_done_cycle", dcyc, 18);
        check("p00_busy_cycles", nbusy, 18);
        check("p00_violations", viol, 0);

        // {q0,q_minus1} = 10: subtract every iteration.
        run_op(2'b10, 1'b0, nsh, nadd, nsub, ndone, dcyc, nbusy, viol);
        check("p10_shifts", nsh, 8);
        check("p10_subs", nsub, 8);
        check("p10_adds", nadd, 0);
        check("p10_done_cycle", dcyc, 26);
        check("p10_busy_cycles", nbusy, 26);
        check("p10_violations", viol, 0);

        // {q0,q_minus1} = 01: add every iteration.
        run_op(2'b01, 1'b0, nsh, nadd, nsub, ndone, dcyc, nbusy, viol);
        check("p01_shifts", nsh, 8);
        check("p01_adds", nadd, 8);
        check("p01_subs", nsub, 0);
        check("p01_done_cycle", dcyc, 26);
        check("p01_violations", viol, 0);

        // {q0,q_minus1} = 11 with a stray start in cycle 5 while busy.
        run_op(2'b11, 1'b1, nsh, nadd, nsub, ndone, dcyc, nbusy, viol);
        check("p11_restart_shifts", nsh, 8);
        check("p11_restart_done_count", ndone, 1);
        check("p11_restart_done_cycle", dcyc, 18);
        check("p11_restart_busy", nbusy, 18);

        // start held high: second LOAD follows the single IDLE cycle after DONE.
        {q0, q_minus1} = 2'b00;
        start = 1'b1;
        step();                                  // edge 0
        for (int c = 1; c <= 45; c++) begin
            if (load) load_cycles.push_back(c);
            if (done) done_cycles.push_back(c);
            step();
        end
        start = 1'b0;
        check("held_load_count", load_cycles.size(), 3);
        if (load_cycles.size() >= 2) begin
            check("held_load1_cycle", load_cycles[0], 1);
            check("held_load2_cycle", load_cycles[1], 20);
        end else begin
            check("held_load_missing", load_cycles.size(), 2);
        end
        if (done_cycles.size() >= 2) begin
            check("held_done1_cycle", done_cycles[0], 18);
            check("held_done2_cycle", done_cycles[1], 37);
        end else begin
            check("held_done_missing", done_cycles.size(), 2);
        end
        repeat (40) step();                      // let the third run drain
        check("held_drained_idle", int'(state), 1);

        // Reset during the 4th SUB, then a full fresh run.
        {q0, q_minus1} = 2'b10;
        start = 1'b1;
        step();
        start = 1'b0;
        subs = 0;
        for (int c = 1; c <= 40 && subs < 4; c++) begin
            if (sub) subs++;
            if (subs < 4) step();
        end
        check("midrun_in_sub", int'(sub), 1);
        #1 reset = 1'b1;
        #1;
        check("midrun_reset_state", int'(state), 1);
        check("midrun_reset_outputs", int'({load, add, sub, shift, busy, done}), 0);
        @(posedge clk);
        #2 reset = 1'b0;
        repeat (3) step();
        check("midrun_stay_idle", int'(state), 1);
        run_op(2'b10, 1'b0, nsh, nadd, nsub, ndone, dcyc, nbusy, viol);
        check("after_reset_subs", nsub, 8);
        check("after_reset_shifts", nsh, 8);
        check("after_reset_done_cycle", dcyc, 26);

`ifdef BOOTH_ONEHOT_CHECK_EN
        // Corrupt the state vector while in CHECK and expect recovery to IDLE.
        {q0, q_minus1} = 2'b00;
        start = 1'b1;
        step();
        start = 1'b0;
        step();                                  // cycle 2: CHECK
        check("corrupt_in_check", int'(state), 7'b0000100);
        force dut.state_q = 7'b0001100;
        #1;
        check("corrupt_illegal", int'(illegal_state), 1);
        release dut.state_q;
        step();
        check("corrupt_recovered", int'(state), 1);
        check("corrupt_illegal_clear", int'(illegal_state), 0);
        illegal_seen = 0;
`endif
        check("illegal_never_seen", illegal_seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
